// File: rtl/fetch_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_pkg
// Description : Shared types for the fetch/prefetch stage and its bus.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_prefetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic        bd;
    } content_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of content_t; flush beats push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  content_t                   push_data,
    input  logic                       pop,
    input  logic                       flush,
    output content_t                   head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    content_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    // A push into a full queue is legal only when the head leaves the same cycle.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch
// Description : Fetch PC owner, addr_ok/data_ok bus master and prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       redirect_valid,
    input  logic [31:0] redirect_pc,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    output logic       out_valid,
    output content_t   out_cont,
    input  logic       out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_redirect_pc;
    logic            w_resp_take;
    logic            w_push;
    logic            w_pop;
    logic            w_room;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_after;
    content_t        w_push_data;
    content_t        w_head;

    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_resp_take   = ((r_state == REQ) & iresp.addr_ok & iresp.data_ok)
                         | ((r_state == WAIT) & iresp.data_ok);
    assign w_push        = w_resp_take & ~redirect_valid;
    assign w_pop         = out_valid & out_ready;
    // Occupancy once this cycle's push/pop land; decides REQ versus HOLD.
    assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
    assign w_room        = (w_count_after < CW'(DEPTH));

    always_comb begin
        w_push_data       = '0;
        w_push_data.pc    = r_fetch_pc;
        w_push_data.instr = iresp.data;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= REQ;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            if (redirect_valid)
                r_fetch_pc <= w_redirect_pc;
            else if (w_push)
                r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ireq.valid   = ~reset & (r_state == REQ);
        ireq.addr    = reset ? RESET_PC : r_fetch_pc;
        case (r_state)
            REQ: begin
                if (redirect_valid)
                    w_next_state = (iresp.addr_ok & ~iresp.data_ok) ? DROP : REQ;
                else if (iresp.addr_ok & iresp.data_ok)
                    w_next_state = w_room ? REQ : HOLD;
                else if (iresp.addr_ok)
                    w_next_state = WAIT;
            end
            WAIT: begin
                // A response landing in the redirect cycle is consumed here, so no DROP.
                if (redirect_valid)
                    w_next_state = iresp.data_ok ? REQ : DROP;
                else if (iresp.data_ok)
                    w_next_state = w_room ? REQ : HOLD;
            end
            DROP: begin
                if (iresp.data_ok) w_next_state = REQ;
            end
            HOLD: begin
                if (redirect_valid || w_pop) w_next_state = REQ;
            end
            default: w_next_state = REQ;
        endcase
    end

    assign out_valid = ~reset & ~w_empty;
    assign out_cont  = out_valid ? w_head : '0;

    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch
// Description : Directed and random-latency bench for fetch_prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;
    import fetch_prefetch_pkg::*;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp = '0;
    logic        out_valid;
    content_t    out_cont;

    int          n_checks = 0;
    int          n_err = 0;

    bit          bus_auto = 1'b0;
    int unsigned bus_max = 0;
    bit          bus_pend = 1'b0;
    logic [31:0] bus_addr = '0;
    int unsigned addr_wait = 0;
    int unsigned data_wait = 0;

    fetch_prefetch #(
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq           (ireq),
        .iresp          (iresp),
        .out_valid      (out_valid),
        .out_cont       (out_cont),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hc3a5_5a3c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus model: one outstanding request, random addr/data latency up to bus_max.
    task automatic drive();
        #1;
        iresp = '0;
        if (reset) begin
            bus_pend  = 1'b0;
            addr_wait = 0;
        end else if (bus_auto) begin
            if (bus_pend) begin
                if (data_wait == 0) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = mem_word(bus_addr);
                    bus_pend      = 1'b0;
                end else begin
                    data_wait--;
                end
            end else if (ireq.valid) begin
                if (addr_wait == 0) begin
                    iresp.addr_ok = 1'b1;
                    bus_addr      = ireq.addr;
                    addr_wait     = $urandom_range(bus_max, 0);
                    data_wait     = $urandom_range(bus_max, 0);
                    if (data_wait == 0) begin
                        iresp.data_ok = 1'b1;
                        iresp.data    = mem_word(bus_addr);
                    end else begin
                        bus_pend = 1'b1;
                    end
                end else begin
                    addr_wait--;
                end
            end
        end
        #1;
    endtask

    task automatic cyc();
        tick();
        drive();
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1; drive();
        tick(); drive();
        tick(); reset = 1'b0; drive();
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          got;

        // Reset outputs
        cyc(); cyc();
        chk("rst_ireq_valid", ireq.valid, 0);
        chk("rst_ireq_addr", ireq.addr, RPC);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_cont.pc, 0);
        chk("rst_out_instr", out_cont.instr, 0);
        chk("rst_out_misc", {out_cont.exc_valid, out_cont.exc_code, out_cont.bd}, 0);

        // Zero-wait streaming, decode always ready
        tick(); reset = 1'b0; bus_auto = 1'b1; bus_max = 0; out_ready = 1'b1; drive();
        chk("zw_c0_valid", ireq.valid, 1);
        chk("zw_c0_addr", ireq.addr, RPC);
        cyc();
        chk("zw_c1_addr", ireq.addr, RPC + 4);
        chk("zw_c1_outv", out_valid, 1);
        chk("zw_c1_pc", out_cont.pc, RPC);
        chk("zw_c1_instr", out_cont.instr, mem_word(RPC));
        cyc();
        chk("zw_c2_addr", ireq.addr, RPC + 8);
        chk("zw_c2_pc", out_cont.pc, RPC + 4);
        chk("zw_c2_instr", out_cont.instr, mem_word(RPC + 4));
        cyc();
        chk("zw_c3_pc", out_cont.pc, RPC + 8);

        // Decode stalled: fill to DEPTH, then HOLD
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("fill_valid", ireq.valid, 1);
            chk("fill_addr", ireq.addr, RPC + 32'(4 * i));
            cyc();
        end
        chk("hold_valid", ireq.valid, 0);
        chk("hold_outv", out_valid, 1);
        chk("hold_pc", out_cont.pc, RPC);
        cyc();
        chk("hold_valid2", ireq.valid, 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("refill_valid", ireq.valid, 1);
        chk("refill_addr", ireq.addr, RPC + 16);
        chk("refill_head", out_cont.pc, RPC + 4);
        cyc();
        chk("rehold_valid", ireq.valid, 0);

        // Redirect while WAIT: stale response must be dropped
        bus_auto = 1'b0; out_ready = 1'b1;
        do_reset();
        iresp.addr_ok = 1'b1;
        chk("rw_c0_addr", ireq.addr, RPC);
        cyc();
        chk("rw_wait_valid", ireq.valid, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        cyc();
        redirect_valid = 1'b0;
        chk("rw_drop_valid", ireq.valid, 0);
        chk("rw_drop_outv", out_valid, 0);
        cyc();
        chk("rw_drop_valid2", ireq.valid, 0);
        cyc();
        iresp.data_ok = 1'b1; iresp.data = 32'hdead_beef;
        chk("rw_drop_outv2", out_valid, 0);
        cyc();
        chk("rw_req_valid", ireq.valid, 1);
        chk("rw_req_addr", ireq.addr, 32'h8000_0100);
        chk("rw_no_stale", out_valid, 0);
        iresp.addr_ok = 1'b1; iresp.data_ok = 1'b1; iresp.data = mem_word(32'h8000_0100);
        cyc();
        chk("rw_out_valid", out_valid, 1);
        chk("rw_out_pc", out_cont.pc, 32'h8000_0100);
        chk("rw_out_instr", out_cont.instr, mem_word(32'h8000_0100));
        chk("rw_next_addr", ireq.addr, 32'h8000_0104);

        // Redirect in REQ with addr_ok=0: no DROP cycle
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        cyc();
        redirect_valid = 1'b0;
        chk("rr_outv", out_valid, 0);
        chk("rr_valid", ireq.valid, 1);
        chk("rr_addr", ireq.addr, 32'h8000_1000);
        cyc();
        chk("rr_valid2", ireq.valid, 1);
        chk("rr_addr2", ireq.addr, 32'h8000_1000);
        iresp.addr_ok = 1'b1; iresp.data_ok = 1'b1; iresp.data = mem_word(32'h8000_1000);
        cyc();
        chk("rr_out_pc", out_cont.pc, 32'h8000_1000);
        chk("rr_out_instr", out_cont.instr, mem_word(32'h8000_1000));

        // Reset while WAIT with 3 entries queued
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            iresp.addr_ok = 1'b1; iresp.data_ok = 1'b1; iresp.data = mem_word(RPC + 32'(4 * i));
            cyc();
        end
        iresp.addr_ok = 1'b1;
        cyc();
        chk("rs_wait_valid", ireq.valid, 0);
        chk("rs_wait_outv", out_valid, 1);
        chk("rs_wait_head", out_cont.pc, RPC);
        reset = 1'b1;
        #1;
        chk("rs_in_outv", out_valid, 0);
        chk("rs_in_valid", ireq.valid, 0);
        tick(); reset = 1'b0; drive();
        chk("rs_after_outv", out_valid, 0);
        chk("rs_after_valid", ireq.valid, 1);
        chk("rs_after_addr", ireq.addr, RPC);

        // Random bus latency, random decode stalls, 1000 instructions
        bus_auto = 1'b1; bus_max = 5;
        do_reset();
        exp_pc = RPC;
        got = 0;
        for (int c = 0; c < 30000 && got < 1000; c++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            if (out_valid && out_ready) begin
                chk("rnd_pc", out_cont.pc, exp_pc);
                chk("rnd_instr", out_cont.instr, mem_word(exp_pc));
                exp_pc = exp_pc + 4;
                got++;
            end
            cyc();
        end
        chk("rnd_count", got, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch.md
# fetch_prefetch

Next-generation instruction fetch stage: owns the fetch PC, drives the instruction bus with a proper `addr_ok`/`data_ok` handshake, and buffers returned instructions in a parametrised prefetch queue. The decode stage consumes instructions through a valid/ready interface. The block sits between the PC-select logic (redirect source) and decode, replacing the single-cycle combinational fetch. Unlike that fetch, it supports stalls from decode, squashes stale responses on redirect, and fetches ahead by up to `DEPTH` instructions.

## Interface
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'hbfc0_0000, first fetch address after reset.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `ireq`  out  ibus_req_t  {valid, addr} to the instruction bus.
- `iresp`  in  ibus_resp_t  {addr_ok, data_ok, data} from the instruction bus.
- `out_valid`  out  1  queue head is valid.
- `out_cont`  out  content_t  head entry; only `pc` and `instr` are driven, all other fields 0.
- `out_ready`  in  1  decode accepts the head this cycle.

## Operation
- State `fetch_pc` holds the next address to request. It resets to `RESET_PC` and advances by 4 on each accepted (non-stale) response.
- FSM states:
  - `REQ`: `ireq.valid=1`, `ireq.addr=fetch_pc`.
  - `WAIT`: address accepted, data pending.
  - `DROP`: a stale response is pending.
  - `HOLD`: queue full, no request.
- Bus rules:
  - One request outstanding at most.
  - The address is accepted on `valid & addr_ok`. It may change while `addr_ok=0`.
  - `data_ok` may arrive in the same cycle as `addr_ok` or any later cycle.
- Issue condition: `count + inflight < DEPTH`, where `inflight` = 1 in `WAIT`. The FSM enters `HOLD` when this is false and returns to `REQ` when a pop frees a slot.
- Transitions:
  - `REQ`, addr_ok & data_ok: push, stay in `REQ` (or go to `HOLD`).
  - `REQ`, addr_ok only: go to `WAIT`.
  - `WAIT`, data_ok: push, go to `REQ`/`HOLD`.
  - `DROP`, data_ok: discard, go to `REQ`.
- Push writes the entry `{pc=fetch_pc, instr=iresp.data}`. Pop occurs on `out_valid & out_ready`.
- Redirect (highest priority):
  - The queue is emptied and `fetch_pc ← redirect_pc`.
  - From `WAIT`, or from `REQ` with addr_ok=1 and data_ok=0 in the same cycle: go to `DROP`.
  - From `REQ` with addr_ok=0: go to `REQ` with the new address next cycle.
  - From `HOLD`: go to `REQ`.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is still accepted by decode but ignored by the queue (already flushed).
- Simultaneous push and pop when full: both occur, and `count` is unchanged.
- Reset in any state:
  - Queue is emptied, FSM goes to `REQ`, `fetch_pc=RESET_PC`.
  - Any outstanding bus response is ignored for one cycle only. The bus is reset together with this block.

## Timing
- Outputs during reset: `ireq.valid=0`, `ireq.addr=RESET_PC`, `out_valid=0`, `out_cont=0`.
- First cycle after reset: `ireq.valid=1`, addr=`RESET_PC`.
- Queue latency: data accepted at cycle t is visible as `out_valid` at t+1. There is no bypass.
- Redirect at cycle t:
  - `out_valid=0` at t+1.
  - `ireq.addr=redirect_pc` at t+1, or after the stale `data_ok` if in `DROP`.
- Throughput with a zero-wait bus (addr_ok & data_ok same cycle): 1 instruction/cycle.
- `count` width is $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Structure
- `fetch_state_t` (REQ/WAIT/DROP/HOLD) and the default `RESET_PC` go in `cpuhead.svh`. `content_t`, `ibus_req_t` and `ibus_resp_t` are already defined there.
- Sub-module `fetch_fifo`: a DEPTH-entry synchronous FIFO of `content_t` with `push`, `pop`, `flush`, `full`, `empty` and `count`. Flush has priority over push and pop.
- The top level holds the FSM, `fetch_pc` and the bus interface.

## Test plan
- **Reset, zero-wait bus, `out_ready=1`:** addresses bfc00000, bfc00004, bfc00008 on consecutive cycles; `out_cont.pc` follows one cycle later with the matching data.
- **`out_ready=0`, DEPTH=4:**
  - Exactly 4 responses are pushed, then `ireq.valid=0` (`HOLD`).
  - Raising `out_ready` for one cycle yields one new request the following cycle.
- **Redirect to 8000_0100 while in `WAIT` (data_ok 3 cycles later):**
  - Stale data is never output.
  - The next request is 8000_0100, and the first output pc is 8000_0100.
- **Redirect in `REQ` with addr_ok=0:** the address switches to the new pc next cycle with `valid` held high, and no `DROP` cycle occurs.
- **Bus with random addr_ok/data_ok delays (0–5 cycles), 1000 instructions:** the output pc sequence is strictly +4, and each instr matches its memory model word.
- **Reset asserted while in `WAIT` with 3 entries queued:** the next cycle shows `out_valid=0`, and the first request after reset is `RESET_PC`.
